// File: rtl/fft256_stage_sequencer.sv
// Control and addressing engine for an in-place radix-2 DIT FFT: walks every stage and
// butterfly, feeds the butterfly unit and writes its results back to the read addresses.
module fft256_stage_sequencer #(
  parameter int N_LOG2 = 8,
  parameter int BF_LAT = 2,
  parameter int DW     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [N_LOG2-1:0] o_rd_addr_a,
  output logic [N_LOG2-1:0] o_rd_addr_b,
  input  logic [DW-1:0]     i_rd_data_a,
  input  logic [DW-1:0]     i_rd_data_b,
  output logic [N_LOG2-2:0] o_tw_addr,
  input  logic [DW-1:0]     i_tw,
  output logic              o_bf_en,
  output logic [DW-1:0]     o_bf_x,
  output logic [DW-1:0]     o_bf_y,
  output logic [DW-1:0]     o_bf_tw,
  input  logic              i_bf_en,
  input  logic [DW-1:0]     i_bf_x,
  input  logic [DW-1:0]     i_bf_y,
  output logic              o_wr_en,
  output logic [N_LOG2-1:0] o_wr_addr_a,
  output logic [N_LOG2-1:0] o_wr_addr_b,
  output logic [DW-1:0]     o_wr_data_a,
  output logic [DW-1:0]     o_wr_data_b
);

  localparam int AW = N_LOG2;
  localparam int KW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2);
  localparam int DL = BF_LAT + 1;
  localparam int CW = $clog2(BF_LAT + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          err_q;
  logic [DL-1:0] dlVld_q;
  logic [AW-1:0] dlAddrA_q [DL];
  logic [AW-1:0] dlAddrB_q [DL];

  logic          issue;
  logic          mismatch;
  logic [AW-1:0] kExt, half, jMask, addrA, addrB;
  logic [KW-1:0] twIdx;

  // Butterfly k of stage s: insert a zero bit at position s of k to get the x address.
  always_comb begin
    kExt  = AW'(k_q);
    half  = AW'(1) << stage_q;
    jMask = half - AW'(1);
    addrA = (((kExt >> stage_q) << stage_q) << 1) | (kExt & jMask);
    addrB = addrA | half;
    twIdx = KW'((kExt & jMask) << (SW'(N_LOG2 - 1) - stage_q));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
      dlVld_q <= '0;
      for (int i = 0; i < DL; i++) begin
        dlAddrA_q[i] <= '0;
        dlAddrB_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      k_q          <= k_d;
      drain_q      <= drain_d;
      err_q        <= err_q | mismatch;
      dlVld_q      <= DL'({dlVld_q, issue});
      dlAddrA_q[0] <= o_rd_addr_a;
      dlAddrB_q[0] <= o_rd_addr_b;
      for (int i = 1; i < DL; i++) begin
        dlAddrA_q[i] <= dlAddrA_q[i-1];
        dlAddrB_q[i] <= dlAddrB_q[i-1];
      end
    end
  end

  // DRAIN holds off the next stage until the last write of this one has landed.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    drain_d = drain_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = ISSUE;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        k_d   = k_q + 1'b1;
        if (k_q == '1) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == CW'(BF_LAT)) begin
          drain_d = '0;
          if (stage_q == SW'(N_LOG2 - 1)) begin
            state_d = DONE;
          end else begin
            stage_d = stage_q + 1'b1;
            k_d     = '0;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writes and error checks are gated by busy so a butterfly still draining after an abort is ignored.
  always_comb begin
    o_busy      = (state_q == ISSUE) || (state_q == DRAIN);
    o_done      = (state_q == DONE);
    o_rd_addr_a = issue ? addrA : '0;
    o_rd_addr_b = issue ? addrB : '0;
    o_tw_addr   = issue ? twIdx : '0;
    o_bf_en     = dlVld_q[0];
    o_bf_x      = dlVld_q[0] ? i_rd_data_a : '0;
    o_bf_y      = dlVld_q[0] ? i_rd_data_b : '0;
    o_bf_tw     = dlVld_q[0] ? i_tw : '0;
    mismatch    = o_busy && (i_bf_en != dlVld_q[DL-1]);
    o_err       = err_q | mismatch;
    o_wr_en     = o_busy && i_bf_en;
    o_wr_addr_a = o_wr_en ? dlAddrA_q[DL-1] : '0;
    o_wr_addr_b = o_wr_en ? dlAddrB_q[DL-1] : '0;
    o_wr_data_a = o_wr_en ? i_bf_x : '0;
    o_wr_data_b = o_wr_en ? i_bf_y : '0;
  end

endmodule

// File: tb/tb_fft256_stage_sequencer.sv
// Bench for fft256_stage_sequencer: behavioural sample RAM, twiddle ROM and butterfly
// around the sequencer, with a timing/address model and a write-back scoreboard.
module tb_fft256_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, start;
  logic        busy, done, err;
  logic [7:0]  rdAddrA, rdAddrB, wrAddrA, wrAddrB;
  logic [6:0]  twAddr;
  logic [31:0] rdDataA, rdDataB, twData;
  logic        bfEnO, bfEnIn, wrEn;
  logic [31:0] bfX, bfY, bfTw, bfXIn, bfYIn, wrDataA, wrDataB;

  fft256_stage_sequencer dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_rd_addr_a(rdAddrA), .o_rd_addr_b(rdAddrB),
    .i_rd_data_a(rdDataA), .i_rd_data_b(rdDataB),
    .o_tw_addr(twAddr), .i_tw(twData),
    .o_bf_en(bfEnO), .o_bf_x(bfX), .o_bf_y(bfY), .o_bf_tw(bfTw),
    .i_bf_en(bfEnIn), .i_bf_x(bfXIn), .i_bf_y(bfYIn),
    .o_wr_en(wrEn), .o_wr_addr_a(wrAddrA), .o_wr_addr_b(wrAddrB),
    .o_wr_data_a(wrDataA), .o_wr_data_b(wrDataB)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal Q14 twiddle W^m = cos - j*sin of 2*pi*m/256
  function automatic logic [31:0] twiddle(input logic [6:0] m);
    real ang;
    int c, s;
    ang = 6.283185307179586 * real'(m) / 256.0;
    c = int'(16384.0 * $cos(ang));
    s = int'(-16384.0 * $sin(ang));
    return {16'(c), 16'(s)};
  endfunction

  function automatic logic [63:0] bfly(input logic [31:0] x, input logic [31:0] y, input logic [31:0] w);
    int xr, xi, yr, yi, wr, wi, pr, pi;
    xr = int'($signed(x[31:16])); xi = int'($signed(x[15:0]));
    yr = int'($signed(y[31:16])); yi = int'($signed(y[15:0]));
    wr = int'($signed(w[31:16])); wi = int'($signed(w[15:0]));
    pr = (yr * wr - yi * wi + 8192) >>> 14;
    pi = (yr * wi + yi * wr + 8192) >>> 14;
    return {16'(xr + pr), 16'(xi + pi), 16'(xr - pr), 16'(xi - pi)};
  endfunction

  logic [31:0] ram [256];
  logic        ldEn = 1'b0;
  logic [7:0]  ldAddr = 8'd0;
  logic [31:0] ldData = 32'd0;
  logic [64:0] bfPipe [4];
  int          bfLat = 2;

  always @(posedge clk) begin
    if (ldEn) ram[ldAddr] <= ldData;
    else if (wrEn) begin
      ram[wrAddrA] <= wrDataA;
      ram[wrAddrB] <= wrDataB;
    end
    rdDataA   <= ram[rdAddrA];
    rdDataB   <= ram[rdAddrB];
    twData    <= twiddle(twAddr);
    bfPipe[0] <= {bfEnO, bfly(bfX, bfY, bfTw)};
    for (int i = 1; i < 4; i++) bfPipe[i] <= bfPipe[i-1];
  end
  assign {bfEnIn, bfXIn, bfYIn} = bfPipe[bfLat-1];

  // Run monitor: expected timing derived from the cycle index after the start pulse.
  typedef struct { int due; logic [7:0] a; logic [7:0] b; } wr_t;
  wr_t wrQ[$];
  bit  monOn = 1'b0, monPrev = 1'b0, checkErr = 1'b1, prevIssuing = 1'b0;
  int  startCyc = 0;
  int  addrErrs, wrErrs, ctrlErrs, wrCnt, busyCnt, doneCnt, doneCyc;
  logic [7:0] trA [1101], trB [1101], trWA [1101], trWB [1101];
  logic [6:0] trTw [1101];

  always @(negedge clk) begin
    int t, s, k;
    logic [7:0] ea, eb;
    logic [6:0] etw;
    bit issuing, expWr;
    wr_t hd;
    if (monOn && !monPrev) begin
      addrErrs = 0; wrErrs = 0; ctrlErrs = 0; wrCnt = 0;
      busyCnt = 0; doneCnt = 0; doneCyc = -1; prevIssuing = 1'b0;
      wrQ.delete();
    end
    monPrev = monOn;
    if (monOn) begin
      t = cyc - startCyc;
      issuing = 1'b0;
      s = 0; k = 0;
      if (t >= 1 && t <= 1048) begin
        s = (t - 1) / 131;
        k = (t - 1) % 131;
        issuing = (k < 128);
      end
      if (busy !== (t >= 1 && t <= 1048)) ctrlErrs++;
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = t;
      end
      if (checkErr && err !== 1'b0) ctrlErrs++;
      if (bfEnO !== prevIssuing) ctrlErrs++;
      if (issuing) begin
        ea  = 8'(((k >> s) << (s + 1)) + (k % (1 << s)));
        eb  = 8'(int'(ea) + (1 << s));
        etw = 7'((k % (1 << s)) << (7 - s));
        if (rdAddrA !== ea || rdAddrB !== eb || twAddr !== etw) addrErrs++;
        wrQ.push_back('{t + 3, ea, eb});
      end
      if (t >= 0 && t <= 1100) begin
        trA[t] = rdAddrA; trB[t] = rdAddrB; trTw[t] = twAddr;
        trWA[t] = wrAddrA; trWB[t] = wrAddrB;
      end
      expWr = (wrQ.size() > 0) && (wrQ[0].due == t);
      if (wrEn !== expWr) wrErrs++;
      else if (expWr) begin
        hd = wrQ.pop_front();
        if (wrAddrA !== hd.a || wrAddrB !== hd.b) wrErrs++;
        wrCnt++;
      end
      prevIssuing = issuing;
    end
  end

  logic [31:0] expQ[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadRam(input int mode);
    for (int i = 0; i < 256; i++) begin
      ldEn   = 1'b1;
      ldAddr = 8'(i);
      case (mode)
        0:       ldData = (i == 0) ? 32'h4000_0000 : 32'h0;
        1:       ldData = 32'h0010_0000;
        default: ldData = $urandom;
      endcase
      tick();
    end
    ldEn = 1'b0;
  endtask

  task automatic launch(input bit mon);
    monOn = 1'b0;
    tick();
    start    = 1'b1;
    startCyc = cyc;
    monOn    = mon;
    tick();
    start = 1'b0;
  endtask

  task automatic waitT(input int tt);
    while (cyc - startCyc < tt) tick();
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0;
    tick(); tick();
    testsRun++;
    if ({busy, done, err, wrEn, bfEnO} !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {busy, done, err, wrEn, bfEnO});
    end
    testsRun++;
    if ({rdAddrA, rdAddrB, twAddr, wrAddrA, wrAddrB} !== 39'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_addr: got %h, expected 0", {rdAddrA, rdAddrB, twAddr, wrAddrA, wrAddrB});
    end
    testsRun++;
    if ({bfX, bfY, bfTw, wrDataA, wrDataB} !== 160'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got %h, expected 0", {bfX, bfY, bfTw, wrDataA, wrDataB});
    end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_impulse();
    int bad, firstBad;
    logic [31:0] exp;
    loadRam(0);
    launch(1'b1);
    waitT(1100);
    monOn = 1'b0;
    for (int i = 0; i < 256; i++) expQ.push_back(32'h4000_0000);
    bad = 0; firstBad = -1;
    for (int i = 0; i < 256; i++) begin
      exp = expQ.pop_front();
      if (ram[i] !== exp) begin
        bad++;
        if (firstBad < 0) firstBad = i;
      end
    end
    testsRun++;
    if (bad !== 0) begin
      testsFailed++;
      $display("[TB] FAIL impulse_spectrum: %0d bad words (first %0d = %h), expected 0 bad", bad, firstBad, ram[firstBad]);
    end
    testsRun++;
    if (doneCyc !== 1049 || doneCnt !== 1) begin
      testsFailed++;
      $display("[TB] FAIL impulse_done: got cycle %0d count %0d, expected cycle 1049 count 1", doneCyc, doneCnt);
    end
    testsRun++;
    if (ctrlErrs !== 0 || err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL impulse_ctrl: got %0d control errors err=%b, expected 0 and 0", ctrlErrs, err);
    end
    testsRun++;
    if (wrCnt !== 1024 || wrErrs !== 0 || wrQ.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL impulse_writes: got %0d writes %0d errors %0d pending, expected 1024 0 0", wrCnt, wrErrs, wrQ.size());
    end
  endtask

  task automatic test_dc();
    int bad;
    loadRam(1);
    launch(1'b1);
    waitT(1100);
    monOn = 1'b0;
    expQ.push_back(32'h1000_0000);
    for (int i = 1; i < 256; i++) expQ.push_back(32'h0);
    testsRun++;
    if (ram[0] !== expQ[0]) begin
      testsFailed++;
      $display("[TB] FAIL dc_bin0: got %h, expected %h", ram[0], expQ[0]);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== expQ.pop_front()) bad++;
    testsRun++;
    if (bad !== 0) begin
      testsFailed++;
      $display("[TB] FAIL dc_spectrum: got %0d bad words, expected 0", bad);
    end
    testsRun++;
    if (busyCnt !== 1048) begin
      testsFailed++;
      $display("[TB] FAIL dc_busy_cycles: got %0d, expected 1048", busyCnt);
    end
  endtask

  task automatic test_address_trace();
    loadRam(2);
    launch(1'b1);
    waitT(1100);
    monOn = 1'b0;
    testsRun++;
    if ({trA[1], trB[1], trTw[1], trA[2], trB[2], trTw[2]} !== {8'd0, 8'd1, 7'd0, 8'd2, 8'd3, 7'd0}) begin
      testsFailed++;
      $display("[TB] FAIL trace_s0: got (%0d,%0d,%0d) (%0d,%0d,%0d), expected (0,1,0) (2,3,0)",
               trA[1], trB[1], trTw[1], trA[2], trB[2], trTw[2]);
    end
    testsRun++;
    if ({trA[919], trB[919], trTw[919]} !== {8'd1, 8'd129, 7'd1}) begin
      testsFailed++;
      $display("[TB] FAIL trace_s7k1: got (%0d,%0d,%0d), expected (1,129,1)", trA[919], trB[919], trTw[919]);
    end
    testsRun++;
    if ({trA[403], trB[403], trTw[403]} !== {8'd17, 8'd25, 7'd16}) begin
      testsFailed++;
      $display("[TB] FAIL trace_s3k9: got (%0d,%0d,%0d), expected (17,25,16)", trA[403], trB[403], trTw[403]);
    end
    testsRun++;
    if ({trWA[4], trWB[4], trWA[5], trWB[5]} !== {8'd0, 8'd1, 8'd2, 8'd3}) begin
      testsFailed++;
      $display("[TB] FAIL trace_writeback: got (%0d,%0d) (%0d,%0d), expected (0,1) (2,3)",
               trWA[4], trWB[4], trWA[5], trWB[5]);
    end
    testsRun++;
    if (addrErrs !== 0 || wrErrs !== 0 || wrCnt !== 1024) begin
      testsFailed++;
      $display("[TB] FAIL trace_all: got %0d addr errs %0d wr errs %0d writes, expected 0 0 1024", addrErrs, wrErrs, wrCnt);
    end
  endtask

  task automatic test_back_to_back_start();
    launch(1'b1);
    waitT(500);
    start = 1'b1; tick(); start = 1'b0;
    waitT(1049);
    start = 1'b1; tick(); start = 1'b0;
    waitT(1150);
    monOn = 1'b0;
    testsRun++;
    if (doneCnt !== 1 || doneCyc !== 1049) begin
      testsFailed++;
      $display("[TB] FAIL start_ignored_done: got count %0d cycle %0d, expected 1 and 1049", doneCnt, doneCyc);
    end
    testsRun++;
    if (ctrlErrs !== 0 || wrCnt !== 1024) begin
      testsFailed++;
      $display("[TB] FAIL start_ignored_ctrl: got %0d errs %0d writes, expected 0 and 1024", ctrlErrs, wrCnt);
    end
    start = 1'b1; tick(); start = 1'b0;
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL restart_from_idle: got busy %b, expected 1", busy);
    end
    rstN = 1'b0; tick(); rstN = 1'b1;
  endtask

  task automatic test_reset_midrun();
    int stray;
    launch(1'b0);
    waitT(300);
    rstN = 1'b0; tick(); rstN = 1'b1;
    testsRun++;
    if ({busy, done, err, wrEn, bfEnO, rdAddrA, rdAddrB, twAddr, bfX} !== 60'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset_outputs: got %h, expected 0", {busy, done, err, wrEn, bfEnO, rdAddrA, rdAddrB, twAddr, bfX});
    end
    stray = 0;
    for (int i = 0; i < 900; i++) begin
      if (wrEn || done || busy) stray++;
      tick();
    end
    testsRun++;
    if (stray !== 0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_no_activity: got %0d active cycles, expected 0", stray);
    end
    launch(1'b1);
    waitT(1100);
    monOn = 1'b0;
    testsRun++;
    if (doneCyc !== 1049 || busyCnt !== 1048 || wrErrs !== 0 || addrErrs !== 0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_rerun: got done %0d busy %0d wrerr %0d addrerr %0d, expected 1049 1048 0 0",
               doneCyc, busyCnt, wrErrs, addrErrs);
    end
  endtask

  task automatic test_late_butterfly();
    bfLat = 3;
    launch(1'b0);
    waitT(3);
    testsRun++;
    if (err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL late_bf_before: got err %b at cycle 3, expected 0", err);
    end
    waitT(4);
    testsRun++;
    if (err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL late_bf_rise: got err %b at cycle 4, expected 1", err);
    end
    waitT(1100);
    testsRun++;
    if (err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL late_bf_sticky: got err %b at cycle 1100, expected 1", err);
    end
    rstN = 1'b0; tick(); rstN = 1'b1;
    testsRun++;
    if (err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL late_bf_clear: got err %b after reset, expected 0", err);
    end
    bfLat = 2;
    tick(); tick(); tick();
  endtask

  initial begin
    rstN = 1'b0;
    start = 1'b0;
    test_reset();
    test_impulse();
    test_dc();
    test_address_trace();
    test_back_to_back_start();
    test_reset_midrun();
    test_late_butterfly();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fft256_stage_sequencer.md
Name: fft256_stage_sequencer

Overview:
- Control and addressing engine for the in-place radix-2 decimation-in-time 256-point FFT.
- It is the initiator side of the butterfly interface. It reads operand pairs from the sample RAM and fetches twiddles from the twiddle ROM. It drives the butterfly unit (2-cycle latency), then writes the results back to the same addresses.
- It runs 8 stages of 128 butterflies each, then signals done to the spectral-flux logic.

Parameters:
- N_LOG2, 8, log2 of the FFT length. Gives 8 stages and 128 butterflies per stage.
- BF_LAT, 2, butterfly latency in cycles from o_bf_en to i_bf_en.
- DW, 32, complex word width: {re[31:16], im[15:0]}, signed.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  start pulse; sampled only in IDLE
- o_busy  out  1  high from the first issue cycle through the last write
- o_done  out  1  one-cycle pulse after the final write
- o_err  out  1  sticky; set when i_bf_en disagrees with the expected-valid delay line
- o_rd_addr_a  out  8  RAM read address of operand x
- o_rd_addr_b  out  8  RAM read address of operand y
- i_rd_data_a  in  DW  RAM data for x; arrives 1 cycle after the address
- i_rd_data_b  in  DW  RAM data for y; arrives 1 cycle after the address
- o_tw_addr  out  7  twiddle ROM index
- i_tw  in  DW  twiddle; arrives 1 cycle after the address
- o_bf_en  out  1  butterfly input valid
- o_bf_x  out  DW  butterfly input x
- o_bf_y  out  DW  butterfly input y
- o_bf_tw  out  DW  butterfly input twiddle
- i_bf_en  in  1  butterfly output valid
- i_bf_x  in  DW  butterfly output x
- i_bf_y  in  DW  butterfly output y
- o_wr_en  out  1  RAM write enable (dual port)
- o_wr_addr_a  out  8  RAM write address for x result
- o_wr_addr_b  out  8  RAM write address for y result
- o_wr_data_a  out  DW  RAM write data for x result
- o_wr_data_b  out  DW  RAM write data for y result

Behaviour:
- Reset: all of the following are forced to 0 on the first i_clk edge with i_rst_n low: state (IDLE), stage, k, the delay lines, and every output.
- Reset mid-run aborts the FFT immediately. There are no further writes and no o_done; RAM contents are undefined.
- States and transitions:
  - IDLE -> ISSUE on i_start.
  - ISSUE: one butterfly per cycle, k = 0..127. After k = 127 -> DRAIN.
  - DRAIN: waits BF_LAT+1 cycles, until the last write of the stage has committed. Then it either increments stage and goes to ISSUE, or, if stage = 7, goes to DONE.
  - DONE: pulses o_done, -> IDLE.
- Addressing for stage s, butterfly k:
  - half = 2^s; j = k & (half-1); g = k >> s.
  - addr_a = g*2*half + j; addr_b = addr_a + half.
  - tw index = j << (7-s).
  - Input data must already be in bit-reversed order in the RAM; the output is in natural order.
- Pipeline for a butterfly issued at cycle c:
  - Addresses are driven at c.
  - At c+1, o_bf_en = 1 and o_bf_x/y/tw pass through i_rd_data_a/b and i_tw combinationally.
  - At c+3 (c+1+BF_LAT), i_bf_en is expected.
  - Write addresses are carried in a BF_LAT+1 deep shift register together with a valid bit.
- Write-back: o_wr_en = i_bf_en, data = i_bf_x/i_bf_y, addresses taken from the delay-line head.
- Stage hazard: the next stage's first read occurs at L+4, one cycle after the last write at L+3. The RAM must provide write-then-read coherency across consecutive cycles.
- Timing with i_start at cycle 0:
  - Stage s issues at cycles 1+131s .. 128+131s.
  - Last write at 1048; o_busy is high for cycles 1..1048.
  - o_done = 1 at cycle 1049 only. Total 1049 cycles.
- i_start while not IDLE is ignored. i_start during DONE is also ignored.
- o_err is set when i_bf_en != delay-line valid. It is cleared only by reset. Writes still follow i_bf_en.
- Outside ISSUE+1, o_bf_x/y/tw are 0. When o_wr_en = 0, all wr outputs are 0.
- No arithmetic in this block. Scaling and rounding belong to the butterfly (twiddle 1.0 = 16384).

Test Plan:
- Impulse: RAM[0] = 0x40000000, all others 0; ideal twiddle ROM; real butterfly -> all 256 words = 0x40000000; o_done at cycle 1049; o_err = 0.
- DC: all 256 words = 0x00100000 -> RAM[0] = 0x10000000, RAM[1..255] = 0 (±1 LSB rounding); o_busy high for exactly 1048 cycles.
- Address trace, stub butterfly:
  - stage 0, k=0,1 -> (0,1,tw 0), (2,3,tw 0).
  - stage 7, k=1 -> (1,129,tw 1).
  - stage 3, k=9 -> (17,25,tw 16).
  - Writes repeat the issue addresses 3 cycles later.
- i_start pulsed at cycles 0, 500 and 1049 -> only one run; o_done once at 1049; the pulse at 1049 is ignored; the run repeats only with a new i_start in IDLE.
- i_rst_n low at cycle 300 for one cycle -> next cycle IDLE, all outputs 0, no o_wr_en, no o_done. A subsequent i_start gives a full 1049-cycle run.
- Stub butterfly with 3-cycle latency -> o_err rises at the first expected i_bf_en (cycle 4) and stays high.
